// File: rtl/scanner_link_rx.sv
// Receive side of the scanner serial link: deserializes LSB-first bytes, decodes
// command frames into one-cycle event pulses and captures the byte that follows command 7.
module scanner_link_rx #(
    parameter int GAP_MAX = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_clk,
    input  logic             ser_data,
    output logic             cmd_valid,
    output logic [7:0]       cmd_code,
    output logic             rdy_xfer_p,
    output logic             start_scan_p,
    output logic             buf_full_p,
    output logic             cmd_unknown_p,
    output logic             data_valid,
    output logic [7:0]       data_byte,
    output logic [CNT_W-1:0] data_count,
    output logic             frame_err,
    output logic             busy
);
    localparam logic [0:0] ST_CMD  = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    localparam int GAP_W = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    logic [0:0]       state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             cmd_valid_reg;
    logic [7:0]       cmd_code_reg;
    logic             rdy_xfer_reg;
    logic             start_scan_reg;
    logic             buf_full_reg;
    logic             cmd_unknown_reg;
    logic             data_valid_reg;
    logic [7:0]       data_byte_reg;
    logic [CNT_W-1:0] data_count_reg;
    logic             frame_err_reg;

    logic       frame_done;
    logic [7:0] byte_in;
    logic       busy_int;

    assign byte_in    = {ser_data, shift_reg[7:1]};
    assign frame_done = ser_clk && (bit_cnt_reg == 3'd7);
    // A pending data byte counts as busy so a stalled "data follows" can time out.
    assign busy_int   = (bit_cnt_reg != 3'd0) || (state_reg == ST_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_CMD;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'd0;
            gap_cnt_reg     <= '0;
            cmd_valid_reg   <= 1'b0;
            cmd_code_reg    <= 8'd0;
            rdy_xfer_reg    <= 1'b0;
            start_scan_reg  <= 1'b0;
            buf_full_reg    <= 1'b0;
            cmd_unknown_reg <= 1'b0;
            data_valid_reg  <= 1'b0;
            data_byte_reg   <= 8'd0;
            data_count_reg  <= '0;
            frame_err_reg   <= 1'b0;
        end else begin
            cmd_valid_reg   <= 1'b0;
            rdy_xfer_reg    <= 1'b0;
            start_scan_reg  <= 1'b0;
            buf_full_reg    <= 1'b0;
            cmd_unknown_reg <= 1'b0;
            data_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;

            if (ser_clk) begin
                // A strobe always wins over a timeout that would fire this cycle.
                shift_reg   <= byte_in;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                gap_cnt_reg <= '0;
                if (frame_done) begin
                    if (state_reg == ST_CMD) begin
                        cmd_valid_reg   <= 1'b1;
                        cmd_code_reg    <= byte_in;
                        rdy_xfer_reg    <= (byte_in == 8'd2);
                        start_scan_reg  <= (byte_in == 8'd3);
                        buf_full_reg    <= (byte_in == 8'd4);
                        cmd_unknown_reg <= !((byte_in == 8'd2) || (byte_in == 8'd3) ||
                                             (byte_in == 8'd4) || (byte_in == 8'd7));
                        if (byte_in == 8'd7)
                            state_reg <= ST_DATA;
                    end else begin
                        data_valid_reg <= 1'b1;
                        data_byte_reg  <= byte_in;
                        if (data_count_reg != {CNT_W{1'b1}})
                            data_count_reg <= data_count_reg + CNT_W'(1);
                        state_reg <= ST_CMD;
                    end
                end
            end else if (!busy_int) begin
                gap_cnt_reg <= '0;
            end else if (gap_cnt_reg == GAP_LAST) begin
                frame_err_reg <= 1'b1;
                bit_cnt_reg   <= 3'd0;
                shift_reg     <= 8'd0;
                state_reg     <= ST_CMD;
                gap_cnt_reg   <= '0;
            end else begin
                gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
        end
    end

    assign cmd_valid     = cmd_valid_reg;
    assign cmd_code      = cmd_code_reg;
    assign rdy_xfer_p    = rdy_xfer_reg;
    assign start_scan_p  = start_scan_reg;
    assign buf_full_p    = buf_full_reg;
    assign cmd_unknown_p = cmd_unknown_reg;
    assign data_valid    = data_valid_reg;
    assign data_byte     = data_byte_reg;
    assign data_count    = data_count_reg;
    assign frame_err     = frame_err_reg;
    assign busy          = busy_int;

endmodule

// File: tb/tb_scanner_link_rx.sv
// Directed bench for scanner_link_rx; a second instance with a 2-bit counter
// exercises data_count saturation without sending 65535 bytes.
module tb_scanner_link_rx;
    logic clk = 1'b0;
    logic rst;
    logic ser_clk;
    logic ser_data;

    logic        cmd_valid, rdy_xfer_p, start_scan_p, buf_full_p, cmd_unknown_p;
    logic        data_valid, frame_err, busy;
    logic [7:0]  cmd_code, data_byte;
    logic [15:0] data_count;

    logic        s_cmd_valid, s_rdy, s_start, s_buf, s_unk, s_data_valid, s_frame_err, s_busy;
    logic [7:0]  s_cmd_code, s_data_byte;
    logic [1:0]  s_data_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int cmd_seen = 0;
    int dat_seen = 0;

    logic [6:0] pv;
    assign pv = {cmd_valid, rdy_xfer_p, start_scan_p, buf_full_p, cmd_unknown_p, data_valid, frame_err};

    always #5 clk = ~clk;

    scanner_link_rx #(.GAP_MAX(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .rdy_xfer_p(rdy_xfer_p),
        .start_scan_p(start_scan_p), .buf_full_p(buf_full_p), .cmd_unknown_p(cmd_unknown_p),
        .data_valid(data_valid), .data_byte(data_byte), .data_count(data_count),
        .frame_err(frame_err), .busy(busy)
    );

    scanner_link_rx #(.GAP_MAX(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data),
        .cmd_valid(s_cmd_valid), .cmd_code(s_cmd_code), .rdy_xfer_p(s_rdy),
        .start_scan_p(s_start), .buf_full_p(s_buf), .cmd_unknown_p(s_unk),
        .data_valid(s_data_valid), .data_byte(s_data_byte), .data_count(s_data_count),
        .frame_err(s_frame_err), .busy(s_busy)
    );

    always @(negedge clk) begin
        if (frame_err)  err_seen++;
        if (cmd_valid)  cmd_seen++;
        if (data_valid) dat_seen++;
    end

    task automatic send_bit(input logic b);
        ser_clk  = 1'b1;
        ser_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic idle(input int n);
        ser_clk  = 1'b0;
        ser_data = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ser_clk = 1'b0; ser_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pv !== 7'b0 || busy !== 1'b0 || cmd_code !== 8'h00 || data_byte !== 8'h00 || data_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: pulses=%b busy=%b cmd=%h data=%h cnt=%h required all zero",
                     pv, busy, cmd_code, data_byte, data_count);
        end
        rst = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_rdy_xfer;
        send_byte(8'h02);
        n_checks++;
        if (pv !== 7'b1100000 || cmd_code !== 8'h02) begin
            n_fail++;
            $display("FAIL rdy_xfer: pulses=%b cmd=%h required 1100000 / 02", pv, cmd_code);
        end
        idle(1);
        n_checks++;
        if (pv !== 7'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_xfer_stretch: pulses=%b busy=%b required 0000000 / 0", pv, busy);
        end
        $display("cmd 0x02: cmd=%h", cmd_code);
    endtask

    task automatic test_back_to_back;
        send_byte(8'h07);
        n_checks++;
        if (pv !== 7'b1000000 || cmd_code !== 8'h07 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL data_follows: pulses=%b cmd=%h busy=%b required 1000000 / 07 / 1", pv, cmd_code, busy);
        end
        send_byte(8'h05);
        n_checks++;
        if (pv !== 7'b0000010 || data_byte !== 8'h05 || data_count !== 16'd1 || cmd_code !== 8'h07) begin
            n_fail++;
            $display("FAIL b2b_data: pulses=%b byte=%h cnt=%0d cmd=%h required 0000010 / 05 / 1 / 07",
                     pv, data_byte, data_count, cmd_code);
        end
        idle(1);
        n_checks++;
        if (pv !== 7'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: pulses=%b busy=%b required 0000000 / 0", pv, busy);
        end
        $display("cmd 0x07 + data 0x05: byte=%h count=%0d", data_byte, data_count);
    endtask

    task automatic test_gap_abort;
        int e0, c0;
        e0 = err_seen; c0 = cmd_seen;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        idle(15);
        n_checks++;
        if (frame_err !== 1'b0 || err_seen != e0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_early: frame_err=%b errs=%0d busy=%b required 0 / %0d / 1", frame_err, err_seen, busy, e0);
        end
        idle(1);
        n_checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_fire: frame_err=%b busy=%b required 1 / 0", frame_err, busy);
        end
        idle(2);
        n_checks++;
        if (err_seen - e0 != 1 || cmd_seen != c0) begin
            n_fail++;
            $display("FAIL gap_count: errs=%0d cmds=%0d required 1 / 0", err_seen - e0, cmd_seen - c0);
        end
        send_byte(8'h04);
        n_checks++;
        if (pv !== 7'b1001000 || cmd_code !== 8'h04) begin
            n_fail++;
            $display("FAIL buf_full: pulses=%b cmd=%h required 1001000 / 04", pv, cmd_code);
        end
        $display("gap abort then cmd 0x04: cmd=%h", cmd_code);
    endtask

    task automatic test_gap_resume;
        int e0;
        logic [7:0] b;
        b = 8'h03;
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        idle(15);
        // 16th cycle carries a strobe, colliding with the would-be timeout.
        for (int i = 3; i < 8; i++) send_bit(b[i]);
        n_checks++;
        if (pv !== 7'b1010000 || cmd_code !== 8'h03 || err_seen != e0) begin
            n_fail++;
            $display("FAIL gap_resume: pulses=%b cmd=%h errs=%0d required 1010000 / 03 / 0", pv, cmd_code, err_seen - e0);
        end
        idle(1);
        $display("15-cycle gap then cmd 0x03: cmd=%h", cmd_code);
    endtask

    task automatic test_unknown_and_reset;
        int d0;
        send_byte(8'h09);
        n_checks++;
        if (pv !== 7'b1000100 || cmd_code !== 8'h09) begin
            n_fail++;
            $display("FAIL unknown: pulses=%b cmd=%h required 1000100 / 09", pv, cmd_code);
        end
        send_byte(8'h07);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        d0 = dat_seen;
        ser_clk = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || data_count !== 16'd0 || cmd_code !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b cnt=%0d cmd=%h required 0 / 0 / 00", busy, data_count, cmd_code);
        end
        send_byte(8'h02);
        n_checks++;
        if (pv !== 7'b1100000 || dat_seen != d0 || data_count !== 16'd0) begin
            n_fail++;
            $display("FAIL after_reset: pulses=%b datas=%0d cnt=%0d required 1100000 / 0 / 0", pv, dat_seen - d0, data_count);
        end
        idle(1);
        $display("cmd 0x09 unknown, reset mid data, cmd 0x02: cnt=%0d", data_count);
    endtask

    task automatic test_saturate;
        logic [1:0] exp_sat;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h07);
            send_byte(8'hAA);
            exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_checks++;
            if (data_valid !== 1'b1 || data_byte !== 8'hAA || s_data_count !== exp_sat || data_count !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL saturate_%0d: dv=%b byte=%h sat_cnt=%0d cnt=%0d required 1 / aa / %0d / %0d",
                         i, data_valid, data_byte, s_data_count, data_count, exp_sat, i + 1);
            end
            $display("data 0xAA #%0d: cnt=%0d sat_cnt=%0d", i, data_count, s_data_count);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_rdy_xfer();
        test_back_to_back();
        test_gap_abort();
        test_gap_resume();
        test_unknown_and_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
